ysyx_23060201_mem_arbiter: RTL and testbench
============================================

# ysyx_23060201_mem_arbiter

Shares one memory port between the instruction fetch unit (IFU, read-only) and the load/store path of the EXU (LSU, read/write). It accepts one request at a time, forwards it to the memory port over a valid/ready handshake, waits for the response and returns it to the requester that issued the request. This lets IFU and EXU move from the current zero-latency combinational memory model to a multi-cycle memory. It sits in the top level between IFU/EXU and the memory model.

## Interface
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, data width
- TIMEOUT_CYCLES, 255, number of WAIT cycles before an error response; must be ≥ 1
- clk  in  1  clock; all logic is rising-edge
- rst_n  in  1  reset, asynchronous, active-low
- if_req_valid / if_req_ready  in / out  1  IFU request handshake
- if_addr  in  ADDR_WIDTH  fetch address
- if_resp_valid  out  1  one-cycle response pulse to IFU; there is no ready, so IFU must accept it
- if_rdata  out  DATA_WIDTH  fetched word
- if_resp_err  out  1  response is a timeout error
- ls_req_valid / ls_req_ready  in / out  1  LSU request handshake
- ls_addr  in  ADDR_WIDTH  load/store address
- ls_wen  in  1  1 = write, 0 = read
- ls_wdata  in  DATA_WIDTH  store data
- ls_wmask  in  8  byte mask; used for both reads and writes
- ls_resp_valid, ls_rdata, ls_resp_err  out  1, DATA_WIDTH, 1  LSU response; same rules as the IFU response
- mem_req_valid / mem_req_ready  out / in  1  memory request handshake
- mem_addr, mem_wen, mem_wdata, mem_wmask  out  ADDR_WIDTH, 1, DATA_WIDTH, 8  registered request fields
- mem_resp_valid  in  1  memory response; expected for both reads and writes
- mem_rdata  in  DATA_WIDTH  memory read data

## Operation
- FSM states:
  - IDLE: req_ready is driven combinationally to the picked requester only.
  - REQ: mem_req_valid=1.
  - WAIT: waiting for the memory response.
- IDLE → REQ: when any req_valid is high. In the same cycle the picked request's fields are latched, owner is set, and last_grant is updated.
- Arbitration: 2-way round-robin.
  - A single requester always wins.
  - On a tie, the requester that is not last_grant wins.
- IFU requests are forwarded with mem_wen=0, mem_wmask=8'hFF, mem_wdata=0.
- REQ → WAIT: when mem_req_ready=1. While mem_req_ready=0, mem_req_valid stays high and the mem_* fields stay unchanged.
- WAIT exits to IDLE on either of two events:
  - Normal response: when mem_resp_valid=1, the owner's resp_valid=1, rdata=mem_rdata (combinational pass-through) and resp_err=0.
  - Timeout: a counter is cleared on entry to WAIT and increments each WAIT cycle that has no response. On the WAIT cycle where the counter equals TIMEOUT_CYCLES-1 and there is still no response, the owner's resp_valid=1, resp_err=1, rdata=0.
- If a normal response and the timeout land in the same cycle, the normal response wins.
- mem_resp_valid is ignored in IDLE and REQ. This covers stale responses arriving after a timeout and responses arriving in the acceptance cycle.
- The non-owner's resp_valid is always 0. Both req_ready outputs are 0 outside IDLE.

## Timing
- Reset values (asynchronous, applied immediately):
  - state=IDLE, last_grant=LSU (so the first tie goes to IFU), counter=0.
  - mem_req_valid=0 and all mem_* fields 0.
  - All resp_valid/resp_err = 0 and all rdata = 0.
- req_ready outputs are combinational and may be 1 during reset only as a function of req_valid in IDLE. Requesters must not issue requests during reset.
- Asserting rst_n in REQ or WAIT abandons the transaction: no response is generated and the state returns to IDLE.
- Transaction with zero-wait memory:
  - Accept at cycle T.
  - mem_req_valid at T+1.
  - Earliest response at T+2.
  - IDLE at T+3.
  - The minimum issue interval is therefore 3 cycles.
- Latency from accept to response is 2 + (REQ stall cycles) + (WAIT cycles before the response).

## Structure
- Package ysyx_23060201_mem_pkg contains:
  - State encoding (IDLE/REQ/WAIT).
  - Owner encoding (OWN_IF=0, OWN_LS=1).
  - The IFU default mask constant 8'hFF.
- One sub-module is natural: ysyx_23060201_rr_arb2, a combinational 2-way round-robin picker with inputs req[1:0] and last_grant and output grant one-hot.
- The FSM, request registers and timeout counter (width $clog2(TIMEOUT_CYCLES+1)) live in the top module.

## Test plan
- IFU-only read of 0x80000000, mem_req_ready=1 at T+1, mem_resp_valid with 0x00000413 at T+2 → if_resp_valid=1 and if_rdata=0x00000413 at T+2; ls_resp_valid stays 0.
- After reset, IFU read 0x80000004 and LSU write 0x80001000/0x12345678/mask 0x0F tie → IFU served first; the next memory request is wen=1, addr 0x80001000, wmask 0x0F.
- Four consecutive tied request pairs → memory sees owners in the order IF, LS, IF, LS, IF, LS, IF, LS.
- mem_req_ready held 0 for 5 cycles during an LSU request → mem_req_valid=1 and mem_addr/mem_wdata/mem_wmask unchanged for all 5 cycles; WAIT is entered the cycle after ready.
- TIMEOUT_CYCLES=4 and no response → ls_resp_valid=1, ls_resp_err=1, ls_rdata=0 on the 4th WAIT cycle; a late mem_resp_valid in the following IDLE produces no response.
- rst_n pulsed low during WAIT → all outputs 0 immediately; after release, a tie is granted to IFU; the abandoned requester never receives a response.

Source files
------------

// File: rtl/ysyx_23060201_mem_pkg.sv
// rtl/ysyx_23060201_mem_pkg.sv - shared encodings for the IFU/LSU memory arbiter
package ysyx_23060201_mem_pkg;

  // Arbiter FSM states
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  // Transaction owner; also the bit index of that requester in the grant vector
  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_LS = 1'b1;

  // Instruction fetches always read the full word
  localparam logic [7:0] IF_WMASK = 8'hFF;

endpackage

// File: rtl/ysyx_23060201_rr_arb2.sv
// rtl/ysyx_23060201_rr_arb2.sv - combinational 2-way round-robin picker
module ysyx_23060201_rr_arb2
  import ysyx_23060201_mem_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  output logic [1:0] grant_o
);

  // A lone requester wins outright; on a tie the one not granted last time wins
  always_comb begin
    grant_o = req_i;
    if (req_i == 2'b11) begin
      grant_o = (last_grant_i == OWN_LS) ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/ysyx_23060201_mem_arbiter.sv
// rtl/ysyx_23060201_mem_arbiter.sv - shares one memory port between IFU and LSU
module ysyx_23060201_mem_arbiter
  import ysyx_23060201_mem_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,

  input  logic                  if_req_valid,
  output logic                  if_req_ready,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_resp_valid,
  output logic [DATA_WIDTH-1:0] if_rdata,
  output logic                  if_resp_err,

  input  logic                  ls_req_valid,
  output logic                  ls_req_ready,
  input  logic [ADDR_WIDTH-1:0] ls_addr,
  input  logic                  ls_wen,
  input  logic [DATA_WIDTH-1:0] ls_wdata,
  input  logic [7:0]            ls_wmask,
  output logic                  ls_resp_valid,
  output logic [DATA_WIDTH-1:0] ls_rdata,
  output logic                  ls_resp_err,

  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_wen,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [7:0]            mem_wmask,
  input  logic                  mem_resp_valid,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [1:0]            state_q, state_d;
  logic                  owner_q, owner_d;
  logic                  last_grant_q, last_grant_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  wen_q, wen_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [7:0]            wmask_q, wmask_d;

  logic [1:0] grant;
  logic       in_idle, in_wait;
  logic       resp_hit, timeout_hit, resp_fire;

  ysyx_23060201_rr_arb2 u_rr_arb2 (
    .req_i        ({ls_req_valid, if_req_valid}),
    .last_grant_i (last_grant_q),
    .grant_o      (grant)
  );

  assign in_idle = (state_q == ST_IDLE);
  assign in_wait = (state_q == ST_WAIT);

  // A real response always beats a timeout that lands in the same cycle
  assign resp_hit    = in_wait && mem_resp_valid;
  assign timeout_hit = in_wait && !mem_resp_valid && (cnt_q == CNT_LAST);
  assign resp_fire   = resp_hit || timeout_hit;

  // Request side: only the picked requester sees ready, and only while idle
  always_comb begin
    if_req_ready = in_idle && grant[OWN_IF];
    ls_req_ready = in_idle && grant[OWN_LS];
  end

  // Response routing to the owner; rdata is zero unless a real response is passing through
  always_comb begin
    if_resp_valid = resp_fire && (owner_q == OWN_IF);
    ls_resp_valid = resp_fire && (owner_q == OWN_LS);
    if_resp_err   = timeout_hit && (owner_q == OWN_IF);
    ls_resp_err   = timeout_hit && (owner_q == OWN_LS);
    if_rdata      = (resp_hit && (owner_q == OWN_IF)) ? mem_rdata : '0;
    ls_rdata      = (resp_hit && (owner_q == OWN_LS)) ? mem_rdata : '0;
  end

  assign mem_req_valid = (state_q == ST_REQ);
  assign mem_addr      = addr_q;
  assign mem_wen       = wen_q;
  assign mem_wdata     = wdata_q;
  assign mem_wmask     = wmask_q;

  // Next-state: accept in IDLE, hand off in REQ, wait for response or timeout in WAIT
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    wen_d        = wen_q;
    wdata_d      = wdata_q;
    wmask_d      = wmask_q;
    case (state_q)
      ST_IDLE: begin
        if (|grant) begin
          state_d = ST_REQ;
          if (grant[OWN_LS]) begin
            owner_d      = OWN_LS;
            last_grant_d = OWN_LS;
            addr_d       = ls_addr;
            wen_d        = ls_wen;
            wdata_d      = ls_wdata;
            wmask_d      = ls_wmask;
          end else begin
            owner_d      = OWN_IF;
            last_grant_d = OWN_IF;
            addr_d       = if_addr;
            wen_d        = 1'b0;
            wdata_d      = '0;
            wmask_d      = IF_WMASK;
          end
        end
      end
      ST_REQ: begin
        if (mem_req_ready) begin
          state_d = ST_WAIT;
          cnt_d   = '0;
        end
      end
      ST_WAIT: begin
        if (resp_fire) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and request registers; reset abandons any transaction in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      owner_q      <= OWN_IF;
      last_grant_q <= OWN_LS;
      cnt_q        <= '0;
      addr_q       <= '0;
      wen_q        <= 1'b0;
      wdata_q      <= '0;
      wmask_q      <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      wen_q        <= wen_d;
      wdata_q      <= wdata_d;
      wmask_q      <= wmask_d;
    end
  end

endmodule

// File: tb/tb_ysyx_23060201_mem_arbiter.sv
// tb/tb_ysyx_23060201_mem_arbiter.sv - directed self-checking bench for the memory arbiter
module tb_ysyx_23060201_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req_valid, if_req_ready, if_resp_valid, if_resp_err;
  logic [31:0] if_addr, if_rdata;
  logic        ls_req_valid, ls_req_ready, ls_wen, ls_resp_valid, ls_resp_err;
  logic [31:0] ls_addr, ls_wdata, ls_rdata;
  logic [7:0]  ls_wmask;
  logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [7:0]  mem_wmask;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ysyx_23060201_mem_arbiter #(
    .ADDR_WIDTH     (32),
    .DATA_WIDTH     (32),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .if_req_valid   (if_req_valid),
    .if_req_ready   (if_req_ready),
    .if_addr        (if_addr),
    .if_resp_valid  (if_resp_valid),
    .if_rdata       (if_rdata),
    .if_resp_err    (if_resp_err),
    .ls_req_valid   (ls_req_valid),
    .ls_req_ready   (ls_req_ready),
    .ls_addr        (ls_addr),
    .ls_wen         (ls_wen),
    .ls_wdata       (ls_wdata),
    .ls_wmask       (ls_wmask),
    .ls_resp_valid  (ls_resp_valid),
    .ls_rdata       (ls_rdata),
    .ls_resp_err    (ls_resp_err),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_addr       (mem_addr),
    .mem_wen        (mem_wen),
    .mem_wdata      (mem_wdata),
    .mem_wmask      (mem_wmask),
    .mem_resp_valid (mem_resp_valid),
    .mem_rdata      (mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // Starting in a REQ cycle: accept at once, answer in the next cycle, end in IDLE
  task automatic mem_serve(input string tag, input logic [31:0] exp_addr, input logic exp_wen,
                           input logic [31:0] exp_wdata, input logic [31:0] exp_mask,
                           input logic exp_ls, input logic [31:0] rdata);
    mem_req_ready = 1'b1;
    settle();
    chk({tag, ".mem_req_valid"}, 32'(mem_req_valid), 1);
    chk({tag, ".mem_addr"},      mem_addr,           exp_addr);
    chk({tag, ".mem_wen"},       32'(mem_wen),       32'(exp_wen));
    chk({tag, ".mem_wdata"},     mem_wdata,          exp_wdata);
    chk({tag, ".mem_wmask"},     32'(mem_wmask),     exp_mask);
    tick();
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b1;
    mem_rdata      = rdata;
    settle();
    chk({tag, ".if_resp_valid"}, 32'(if_resp_valid), exp_ls ? 0 : 1);
    chk({tag, ".ls_resp_valid"}, 32'(ls_resp_valid), exp_ls ? 1 : 0);
    chk({tag, ".if_rdata"},      if_rdata,           exp_ls ? 0 : rdata);
    chk({tag, ".ls_rdata"},      ls_rdata,           exp_ls ? rdata : 0);
    chk({tag, ".resp_err"},      32'(if_resp_err | ls_resp_err), 0);
    tick();
    mem_resp_valid = 1'b0;
    mem_rdata      = '0;
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    if_req_valid   = 1'b0;
    if_addr        = '0;
    ls_req_valid   = 1'b0;
    ls_addr        = '0;
    ls_wen         = 1'b0;
    ls_wdata       = '0;
    ls_wmask       = '0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_rdata      = '0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic exp_ls;

    do_reset();
    chk("rst.mem_req_valid", 32'(mem_req_valid), 0);
    chk("rst.mem_addr",      mem_addr,           0);
    chk("rst.mem_wmask",     32'(mem_wmask),     0);
    chk("rst.resp_valid",    32'({if_resp_valid, ls_resp_valid}), 0);
    chk("rst.rdata",         if_rdata | ls_rdata, 0);

    // IFU-only read, zero-wait memory
    if_req_valid = 1'b1;
    if_addr      = 32'h8000_0000;
    settle();
    chk("t1.if_req_ready", 32'(if_req_ready), 1);
    chk("t1.ls_req_ready", 32'(ls_req_ready), 0);
    tick();
    if_req_valid = 1'b0;
    settle();
    chk("t1.busy_ready", 32'(if_req_ready), 0);
    mem_serve("t1", 32'h8000_0000, 1'b0, 0, 'hFF, 1'b0, 32'h0000_0413);
    settle();
    chk("t1.after_if_resp", 32'(if_resp_valid), 0);

    // Tie after reset: IFU first, then the LSU write
    do_reset();
    if_req_valid = 1'b1;
    if_addr      = 32'h8000_0004;
    ls_req_valid = 1'b1;
    ls_addr      = 32'h8000_1000;
    ls_wen       = 1'b1;
    ls_wdata     = 32'h1234_5678;
    ls_wmask     = 8'h0F;
    settle();
    chk("t2.if_req_ready", 32'(if_req_ready), 1);
    chk("t2.ls_req_ready", 32'(ls_req_ready), 0);
    tick();
    if_req_valid = 1'b0;
    mem_serve("t2.if", 32'h8000_0004, 1'b0, 0, 'hFF, 1'b0, 32'h1111_0000);
    settle();
    chk("t2.ls_req_ready", 32'(ls_req_ready), 1);
    tick();
    ls_req_valid = 1'b0;
    mem_serve("t2.ls", 32'h8000_1000, 1'b1, 32'h1234_5678, 'h0F, 1'b1, 32'h0);

    // Four back-to-back tied pairs alternate IF, LS, IF, LS, ...
    if_req_valid = 1'b1;
    ls_req_valid = 1'b1;
    ls_wen       = 1'b0;
    ls_wdata     = 32'hA5A5_0000;
    ls_wmask     = 8'h03;
    for (int i = 0; i < 8; i++) begin
      if_addr = 32'h8000_0100 + 32'(i * 16);
      ls_addr = 32'h8000_2000 + 32'(i * 16);
      exp_ls  = (i % 2) == 1;
      settle();
      chk($sformatf("rr%0d.if_req_ready", i), 32'(if_req_ready), exp_ls ? 0 : 1);
      chk($sformatf("rr%0d.ls_req_ready", i), 32'(ls_req_ready), exp_ls ? 1 : 0);
      tick();
      mem_serve($sformatf("rr%0d", i), exp_ls ? ls_addr : if_addr, 1'b0,
                exp_ls ? 32'hA5A5_0000 : 0, exp_ls ? 'h03 : 'hFF, exp_ls, 32'(i + 100));
    end
    if_req_valid = 1'b0;
    ls_req_valid = 1'b0;

    // LSU write with mem_req_ready held low for 5 cycles
    ls_req_valid = 1'b1;
    ls_addr      = 32'h8000_3000;
    ls_wen       = 1'b1;
    ls_wdata     = 32'hCAFE_F00D;
    ls_wmask     = 8'hF0;
    tick();
    ls_req_valid = 1'b0;
    ls_addr      = '0;
    ls_wdata     = '0;
    ls_wmask     = '0;
    for (int i = 0; i < 5; i++) begin
      settle();
      chk($sformatf("stall%0d.valid", i), 32'(mem_req_valid), 1);
      chk($sformatf("stall%0d.addr", i),  mem_addr,           32'h8000_3000);
      chk($sformatf("stall%0d.wdata", i), mem_wdata,          32'hCAFE_F00D);
      chk($sformatf("stall%0d.wmask", i), 32'(mem_wmask),     'hF0);
      tick();
    end
    mem_req_ready = 1'b1;
    settle();
    chk("stall.ready_cycle_valid", 32'(mem_req_valid), 1);
    tick();
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b1;
    settle();
    chk("stall.wait_valid", 32'(mem_req_valid), 0);
    chk("stall.ls_resp",    32'(ls_resp_valid), 1);
    tick();
    mem_resp_valid = 1'b0;

    // Timeout with TIMEOUT_CYCLES=4, then a stale response in IDLE
    ls_req_valid = 1'b1;
    ls_addr      = 32'h8000_4000;
    ls_wen       = 1'b0;
    tick();
    ls_req_valid  = 1'b0;
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    mem_rdata     = 32'hDEAD_BEEF;
    for (int i = 1; i <= 3; i++) begin
      settle();
      chk($sformatf("to.wait%0d.ls_resp", i), 32'(ls_resp_valid), 0);
      tick();
    end
    settle();
    chk("to.ls_resp_valid", 32'(ls_resp_valid), 1);
    chk("to.ls_resp_err",   32'(ls_resp_err),   1);
    chk("to.ls_rdata",      ls_rdata,           0);
    chk("to.if_resp_valid", 32'(if_resp_valid), 0);
    tick();
    mem_resp_valid = 1'b1;
    settle();
    chk("to.stale.ls_resp", 32'(ls_resp_valid), 0);
    chk("to.stale.ls_err",  32'(ls_resp_err),   0);
    chk("to.stale.ls_rdata", ls_rdata,          0);
    tick();
    mem_resp_valid = 1'b0;
    mem_rdata      = '0;

    // Reset during WAIT abandons the IFU fetch
    if_req_valid = 1'b1;
    if_addr      = 32'h8000_5000;
    tick();
    if_req_valid  = 1'b0;
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    settle();
    chk("rw.in_wait_valid", 32'(mem_req_valid), 0);
    chk("rw.in_wait_addr",  mem_addr,           32'h8000_5000);
    rst_n = 1'b0;
    settle();
    chk("rw.mem_addr",   mem_addr,        0);
    chk("rw.mem_wmask",  32'(mem_wmask),  0);
    chk("rw.resp_valid", 32'({if_resp_valid, ls_resp_valid}), 0);
    tick();
    rst_n          = 1'b1;
    mem_resp_valid = 1'b1;
    mem_rdata      = 32'h5555_AAAA;
    settle();
    chk("rw.stale.if_resp", 32'(if_resp_valid), 0);
    chk("rw.stale.if_rdata", if_rdata,          0);
    tick();
    mem_resp_valid = 1'b0;
    mem_rdata      = '0;
    if_req_valid   = 1'b1;
    if_addr        = 32'h8000_6000;
    ls_req_valid   = 1'b1;
    ls_addr        = 32'h8000_7000;
    ls_wen         = 1'b0;
    ls_wmask       = 8'hFF;
    settle();
    chk("rw.tie.if_ready", 32'(if_req_ready), 1);
    chk("rw.tie.ls_ready", 32'(ls_req_ready), 0);
    tick();
    if_req_valid = 1'b0;
    mem_serve("rw.if", 32'h8000_6000, 1'b0, 0, 'hFF, 1'b0, 32'h0000_0013);
    tick();
    ls_req_valid = 1'b0;
    mem_serve("rw.ls", 32'h8000_7000, 1'b0, 0, 'hFF, 1'b1, 32'h0000_0077);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
